// File: rtl/tmds_pkg.sv
// Shared TMDS types, control symbols and 8b/10b helper functions
// for the DVI transmit encoder.
package tmds_pkg;

  localparam int SYM_W = 10;

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic signed [4:0] disp_t;

  localparam sym_t CTRL_00 = 10'h354;
  localparam sym_t CTRL_01 = 10'h0AB;
  localparam sym_t CTRL_10 = 10'h154;
  localparam sym_t CTRL_11 = 10'h2AB;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic sym_t ctrl_symbol(input logic [1:0] c);
    sym_t s;
    case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  // Stage-1 transition minimisation; bit 8 flags the XOR path.
  function automatic logic [8:0] min_transitions(input logic [7:0] d);
    logic [3:0] n;
    logic       xnor_sel;
    logic [8:0] q;
    n        = ones8(d);
    xnor_sel = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = xnor_sel ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xnor_sel;
    return q;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: registered transition minimisation followed by the
// DC-balancing stage with its own running disparity counter.
module tmds_channel_encoder
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic [1:0] ctrl,
  input  logic       de,
  output logic [9:0] sym
);

  logic [8:0] qm_r;
  logic       de_r;
  logic [1:0] ctrl_r;
  disp_t      cnt;
  disp_t      cnt_nxt;
  disp_t      diff;
  sym_t       sym_nxt;
  logic [4:0] n1x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm_r   <= '0;
      de_r   <= 1'b0;
      ctrl_r <= 2'b00;
    end else begin
      qm_r   <= min_transitions(d);
      de_r   <= de;
      ctrl_r <= ctrl;
    end
  end

  // diff = N1 - N0 over q_m[7:0], always within -8..+8
  assign n1x  = {1'b0, ones8(qm_r[7:0])};
  assign diff = $signed(n1x + n1x - 5'd8);

  always_comb begin
    sym_nxt = ctrl_symbol(ctrl_r);
    cnt_nxt = '0;
    if (de_r) begin
      if (cnt == 0 || diff == 0) begin
        sym_nxt = {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]};
        cnt_nxt = qm_r[8] ? cnt + diff : cnt - diff;
      end else if ((cnt > 0 && diff > 0) || (cnt < 0 && diff < 0)) begin
        sym_nxt = {1'b1, qm_r[8], ~qm_r[7:0]};
        cnt_nxt = cnt + (qm_r[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
        sym_nxt = {1'b0, qm_r[8], qm_r[7:0]};
        cnt_nxt = cnt + diff - (qm_r[8] ? 5'sd0 : 5'sd2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym <= CTRL_00;
      cnt <= '0;
    end else begin
      sym <= sym_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/tmds_tx_encoder.sv
// DVI transmit encoder: three TMDS lanes plus aligned data-enable.
// Build with TMDS_TX_PATTERN_EN to add the internal horizontal-ramp test source.
module tmds_tx_encoder
  import tmds_pkg::*;
(
  input  logic       I_clk,
  input  logic       I_rst_n,
`ifdef TMDS_TX_PATTERN_EN
  input  logic       I_pattern_sel,
`endif
  input  logic [7:0] I_rgb_r,
  input  logic [7:0] I_rgb_g,
  input  logic [7:0] I_rgb_b,
  input  logic       I_rgb_hs,
  input  logic       I_rgb_vs,
  input  logic       I_rgb_de,
  output logic [9:0] O_tmds_ch0,
  output logic [9:0] O_tmds_ch1,
  output logic [9:0] O_tmds_ch2,
  output logic       O_de
);

  logic [7:0] r_in, g_in, b_in;
  logic       de_p1;

`ifdef TMDS_TX_PATTERN_EN
  logic [7:0] pix_cnt;
  logic [7:0] pat_val;
  logic       de_q;

  // Ramp restarts at 0 on the first active pixel of each line.
  assign pat_val = (I_rgb_de && !de_q) ? 8'd0 : pix_cnt;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pix_cnt <= '0;
      de_q    <= 1'b0;
    end else begin
      de_q <= I_rgb_de;
      if (I_rgb_de) pix_cnt <= pat_val + 8'd1;
    end
  end

  assign r_in = I_pattern_sel ? pat_val : I_rgb_r;
  assign g_in = I_pattern_sel ? pat_val : I_rgb_g;
  assign b_in = I_pattern_sel ? pat_val : I_rgb_b;
`else
  assign r_in = I_rgb_r;
  assign g_in = I_rgb_g;
  assign b_in = I_rgb_b;
`endif

  tmds_channel_encoder u_ch0 (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .d     (b_in),
    .ctrl  ({I_rgb_vs, I_rgb_hs}),
    .de    (I_rgb_de),
    .sym   (O_tmds_ch0)
  );

  tmds_channel_encoder u_ch1 (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .d     (g_in),
    .ctrl  (2'b00),
    .de    (I_rgb_de),
    .sym   (O_tmds_ch1)
  );

  tmds_channel_encoder u_ch2 (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .d     (r_in),
    .ctrl  (2'b00),
    .de    (I_rgb_de),
    .sym   (O_tmds_ch2)
  );

  // de follows the same two register stages as the symbols
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      de_p1 <= 1'b0;
      O_de  <= 1'b0;
    end else begin
      de_p1 <= I_rgb_de;
      O_de  <= de_p1;
    end
  end

endmodule
